uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver for the 8N1 UART link: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). Idle line is high.
- Oversamples serial_in on a sample-tick enable and locates each bit centre from the start-bit falling edge.
- Holds each received byte in a one-entry output register, with a ready/ack handshake and sticky framing and overrun error flags.
- Sits on the receive side of the serial link, opposite the uart_tx transmitter, and feeds the host-side data bus.

Parameters:
- OVERSAMPLE, 16, number of sample_tick pulses per bit period. Must be even and >= 4.
- SYNC_STAGES, 2, number of flip-flops in the serial_in synchroniser. Must be >= 2.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- sample_tick, input, 1, one-clk enable pulse at OVERSAMPLE x baud rate. All receive timing advances only on cycles where it is 1.
- serial_in, input, 1, asynchronous serial line.
- read_byte, input, 1, one-clk acknowledge from the consumer. Clears byte_ready.
- clear_errors, input, 1, one-clk pulse that clears both error flags.
- data_out, output, 8, last correctly framed byte.
- byte_ready, output, 1, data_out holds an unread byte.
- framing_error, output, 1, sticky. Stop bit was sampled as 0.
- overrun_error, output, 1, sticky. A byte completed while byte_ready was still 1.
- busy, output, 1, receiver is anywhere other than IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - All synchroniser flops go to 1.
  - Counters and shift register go to 0.
  - Outputs: data_out=0x00, byte_ready=0, framing_error=0, overrun_error=0, busy=0.
  - Reset asserted mid-frame abandons the frame. No byte and no error result from it.
- Synchroniser: serial_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s.
- Counters: sample_cnt counts 0..OVERSAMPLE-1; bit_cnt counts 0..7. The state machine changes only on cycles with sample_tick=1.
- IDLE:
  - If rx_s=0 on a tick: go to START, sample_cnt=0.
- START:
  - On each tick, if sample_cnt = OVERSAMPLE/2-1, this is the start-bit centre:
    - rx_s=0: go to DATA, sample_cnt=0, bit_cnt=0.
    - rx_s=1: treat as a glitch and return to IDLE. No error flag is set.
  - Otherwise increment sample_cnt.
- DATA:
  - On each tick, if sample_cnt = OVERSAMPLE-1: shift rx_s into shift_reg[7] (right shift, so the first bit received ends up in bit 0), set sample_cnt=0, increment bit_cnt.
  - After the 8th sample, go to STOP.
  - Otherwise increment sample_cnt.
- STOP:
  - On the tick where sample_cnt = OVERSAMPLE-1:
    - rx_s=1: on the next edge, data_out<=shift_reg and byte_ready<=1. If byte_ready was already 1 and read_byte is 0 in that cycle, overrun_error<=1 (the new byte overwrites). Go to IDLE.
    - rx_s=0: framing_error<=1. data_out and byte_ready are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay here until rx_s=1 on a tick, then go to IDLE. This stops a break condition from producing back-to-back false frames.
- Latency at OVERSAMPLE=16:
  - Start-bit centre is sampled on the 8th tick after the tick that sees rx_s=0.
  - Bit k is sampled at tick 8+16(k+1), where k = 0..7.
  - Stop bit is sampled at tick 152.
  - byte_ready rises on the clk edge after tick 152.
  - End to end this is 152 ticks plus SYNC_STAGES clk after the line's falling edge.
- Handshake:
  - read_byte=1 clears byte_ready on the next edge.
  - read_byte=0 while byte_ready=0 has no effect.
  - If read_byte and a new byte completion happen in the same cycle, the new byte wins: byte_ready stays 1, data_out is updated, and no overrun is flagged.
- Errors:
  - clear_errors=1 clears both flags on the next edge.
  - If clear_errors coincides with an error being set, the set wins.
- busy=1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
- OVERSAMPLE=16, sample_tick tied high, transmit 0xA5 with a good stop bit.
  - Required: byte_ready rises 152+2 clk after the falling edge, data_out=0xA5, both error flags 0, busy=0 afterwards.
- Line low for 4 ticks, then high.
  - Required: returns to IDLE from START, byte_ready=0, framing_error=0, no byte delivered.
- Transmit 0x3C with the stop bit forced to 0, line held low 40 further ticks, then high.
  - Required: framing_error=1, byte_ready=0, data_out keeps its previous value.
  - Required: stays in WAIT_HIGH until rx_s=1. A following 0x5A is then received correctly.
- Send 0x11 then 0x22 with no read_byte.
  - Required: data_out=0x22, byte_ready=1, overrun_error=1.
  - Then clear_errors pulse: overrun_error=0.
- Pulse read_byte in the same cycle that a second byte 0x77 completes.
  - Required: byte_ready stays 1, data_out=0x77, overrun_error=0.
- Assert reset_n=0 during bit 4 of a frame, release, then send 0xC3.
  - Required: all outputs at reset values while in reset, no partial byte afterwards, 0xC3 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detection on an oversampling tick, bit-centre
// sampling, one-entry output register with ready/ack handshake and sticky errors.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_tick,
    input  logic       serial_in,
    input  logic       read_byte,
    input  logic       clear_errors,
    output logic [7:0] data_out,
    output logic       byte_ready,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       busy,
    output logic [2:0] state_dbg
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   fe_q, fe_d;
    logic                   oe_q, oe_d;
    logic                   rx_s;
    logic                   done_ok;
    logic                   done_fe;

    // Idle-high line: synchroniser resets to 1 so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            fe_q         <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            fe_q         <= fe_d;
            oe_q         <= oe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        done_ok      = 1'b0;
        done_fe      = 1'b0;

        if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d      = S_START;
                        sample_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (sample_cnt_q == HALF_LAST) begin
                        // A start bit that is high again at its centre is a glitch, not a frame.
                        if (!rx_s) begin
                            state_d      = S_DATA;
                            sample_cnt_d = '0;
                            bit_cnt_d    = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (sample_cnt_q == BIT_LAST) begin
                        shift_d      = {rx_s, shift_q[7:1]};
                        sample_cnt_d = '0;
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (sample_cnt_q == BIT_LAST) begin
                        sample_cnt_d = '0;
                        if (rx_s) begin
                            done_ok = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            done_fe = 1'b1;
                            state_d = S_WAIT_HIGH;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake: byte_ready=1 means data_out holds an unread byte; a read_byte
    // pulse consumes it on the next edge unless a new byte lands in that same
    // cycle, in which case the new byte is presented and no overrun is counted.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        fe_d    = fe_q;
        oe_d    = oe_q;

        if (done_ok) begin
            data_d  = shift_q;
            ready_d = 1'b1;
        end else if (read_byte) begin
            ready_d = 1'b0;
        end

        if (clear_errors) begin
            fe_d = 1'b0;
            oe_d = 1'b0;
        end
        if (done_fe) begin
            fe_d = 1'b1;
        end
        if (done_ok && ready_q && !read_byte) begin
            oe_d = 1'b1;
        end
    end

    assign data_out      = data_q;
    assign byte_ready    = ready_q;
    assign framing_error = fe_q;
    assign overrun_error = oe_q;
    assign busy          = (state_q != S_IDLE);
    assign state_dbg     = state_q;

endmodule
